instr_fetch: RTL and testbench

Instruction-fetch stage directly upstream of the control decoder. Holds the program counter, issues one word request at a time to instruction memory, and captures the returned 32-bit instruction into a registered output. Presents the opcode and ALU-op fields the decoder consumes. Accepts downstream stall and branch/jump redirect from later stages.

---
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, single-outstanding imem request, captured insn.
// Optional perf counters enabled by defining INSTR_FETCH_PERF_EN.
module instr_fetch #(
   parameter int              PC_W     = 12,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clock,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_data,
   input  logic            imem_valid,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [31:0]     insn,
   output logic            insn_valid,
   output logic [PC_W-1:0] insn_pc,
   output logic [PC_W-1:0] insn_pc_plus1,
   output logic [4:0]      opcode,
   output logic [4:0]      alu_op,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_stall_cycles
);

   localparam logic [1:0] S_START = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            kill_q, kill_d;
   logic [31:0]     insn_q, insn_d;
   logic [PC_W-1:0] insn_pc_q, insn_pc_d;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      kill_d    = kill_q;
      insn_d    = insn_q;
      insn_pc_d = insn_pc_q;
      unique case (state_q)
         S_START: begin
            if (redirect) pc_d = redirect_pc;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_WAIT;
            if (redirect) begin
               pc_d   = redirect_pc;
               kill_d = 1'b1;
            end
         end
         S_WAIT: begin
            // A response racing a redirect is as stale as a killed one
            if (imem_valid) begin
               kill_d = 1'b0;
               if (redirect) begin
                  pc_d    = redirect_pc;
                  state_d = S_FETCH;
               end else if (kill_q) begin
                  state_d = S_FETCH;
               end else begin
                  insn_d    = imem_data;
                  insn_pc_d = pc_q;
                  pc_d      = pc_q + PC_W'(1);
                  state_d   = S_HOLD;
               end
            end else if (redirect) begin
               pc_d   = redirect_pc;
               kill_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = S_FETCH;
            end else if (!stall) begin
               state_d = S_FETCH;
            end
         end
         default: state_d = S_START;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_START;
         pc_q      <= RESET_PC;
         kill_q    <= 1'b0;
         insn_q    <= '0;
         insn_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         kill_q    <= kill_d;
         insn_q    <= insn_d;
         insn_pc_q <= insn_pc_d;
      end
   end

   assign imem_req      = (state_q == S_FETCH);
   assign imem_addr     = pc_q;
   assign insn          = insn_q;
   assign insn_valid    = (state_q == S_HOLD);
   assign insn_pc       = insn_pc_q;
   assign insn_pc_plus1 = insn_pc_q + PC_W'(1);
   assign opcode        = insn_q[31:27];
   assign alu_op        = insn_q[6:2];

`ifdef INSTR_FETCH_PERF_EN
   logic [31:0] fetched_q, stalls_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetched_q <= '0;
         stalls_q  <= '0;
      end else if (state_q == S_HOLD) begin
         if (!stall && !redirect) fetched_q <= fetched_q + 32'd1;
         if (stall) stalls_q <= stalls_q + 32'd1;
      end
   end

   assign perf_fetched      = fetched_q;
   assign perf_stall_cycles = stalls_q;
`else
   assign perf_fetched      = '0;
   assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with PC_W=12, RESET_PC=0.
// Perf expectations follow INSTR_FETCH_PERF_EN when defined.
module tb_instr_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [11:0] imem_addr;
   logic [31:0] imem_data;
   logic        imem_valid;
   logic        stall;
   logic        redirect;
   logic [11:0] redirect_pc;
   logic [31:0] insn;
   logic        insn_valid;
   logic [11:0] insn_pc;
   logic [11:0] insn_pc_plus1;
   logic [4:0]  opcode;
   logic [4:0]  alu_op;
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall_cycles;

   int errors = 0;
   int checks = 0;

   instr_fetch #(.PC_W(12), .RESET_PC(12'h000)) dut (
      .clock             (clock),
      .reset             (reset),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_data         (imem_data),
      .imem_valid        (imem_valid),
      .stall             (stall),
      .redirect          (redirect),
      .redirect_pc       (redirect_pc),
      .insn              (insn),
      .insn_valid        (insn_valid),
      .insn_pc           (insn_pc),
      .insn_pc_plus1     (insn_pc_plus1),
      .opcode            (opcode),
      .alu_op            (alu_op),
      .perf_fetched      (perf_fetched),
      .perf_stall_cycles (perf_stall_cycles)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts in FETCH at pc, returns d with 1-cycle latency, ends in HOLD.
   task automatic fetch_one(input logic [31:0] d, input logic [11:0] pc,
                            input logic [4:0] op, input logic [4:0] alu);
      logic [11:0] p1;
      p1 = pc + 12'd1;
      chk("req_fetch", 32'(imem_req), 32'd1);
      chk("addr_fetch", 32'(imem_addr), 32'(pc));
      chk("iv_fetch", 32'(insn_valid), 32'd0);
      tick();
      imem_valid = 1'b1;
      imem_data  = d;
      chk("req_wait", 32'(imem_req), 32'd0);
      chk("iv_wait", 32'(insn_valid), 32'd0);
      tick();
      imem_valid = 1'b0;
      imem_data  = 32'h0;
      chk("iv_hold", 32'(insn_valid), 32'd1);
      chk("insn_hold", insn, d);
      chk("insn_pc", 32'(insn_pc), 32'(pc));
      chk("insn_pc_plus1", 32'(insn_pc_plus1), 32'(p1));
      chk("opcode", 32'(opcode), 32'(op));
      chk("alu_op", 32'(alu_op), 32'(alu));
      chk("req_hold", 32'(imem_req), 32'd0);
   endtask

   task automatic chk_perf(input string tag, input logic [31:0] f,
                           input logic [31:0] s);
`ifdef INSTR_FETCH_PERF_EN
      chk({tag, "_fetched"}, perf_fetched, f);
      chk({tag, "_stalls"}, perf_stall_cycles, s);
`else
      chk({tag, "_fetched"}, perf_fetched, 32'd0);
      chk({tag, "_stalls"}, perf_stall_cycles, 32'd0);
`endif
   endtask

   initial begin
      reset       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 12'h0;
      imem_valid  = 1'b0;
      imem_data   = 32'h0;
      #12;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_insn", insn, 32'd0);
      chk("rst_iv", 32'(insn_valid), 32'd0);
      chk("rst_insn_pc", 32'(insn_pc), 32'd0);
      chk("rst_plus1", 32'(insn_pc_plus1), 32'd1);
      chk("rst_opcode", 32'(opcode), 32'd0);
      chk("rst_alu", 32'(alu_op), 32'd0);
      chk_perf("rst", 32'd0, 32'd0);
      reset = 1'b1;
      #1;
      chk("start_req", 32'(imem_req), 32'd0);
      tick();

      fetch_one(32'h00000000, 12'h000, 5'd0, 5'd0);
      tick();
      fetch_one(32'h28A00005, 12'h001, 5'd5, 5'd1);
      tick();
      fetch_one(32'h3C000004, 12'h002, 5'd7, 5'd1);
      tick();

      // stall held in HOLD for 4 cycles
      fetch_one(32'h01084020, 12'h003, 5'd0, 5'd8);
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_iv", 32'(insn_valid), 32'd1);
         chk("stall_insn", insn, 32'h01084020);
         chk("stall_opcode", 32'(opcode), 32'd0);
         chk("stall_alu", 32'(alu_op), 32'd8);
         chk("stall_req", 32'(imem_req), 32'd0);
      end
      stall = 1'b0;
      tick();
      chk("post_stall_req", 32'(imem_req), 32'd1);
      chk("post_stall_addr", 32'(imem_addr), 32'h004);
      chk_perf("stall", 32'd4, 32'd4);

      // redirect pulsed in WAIT, stale response 2 cycles later
      tick();
      chk("rw_req", 32'(imem_req), 32'd0);
      redirect    = 1'b1;
      redirect_pc = 12'h100;
      tick();
      redirect = 1'b0;
      chk("rw_addr", 32'(imem_addr), 32'h100);
      chk("rw_req2", 32'(imem_req), 32'd0);
      tick();
      chk("rw_req3", 32'(imem_req), 32'd0);
      imem_valid = 1'b1;
      imem_data  = 32'hDEADBEEF;
      tick();
      imem_valid = 1'b0;
      chk("rw_iv", 32'(insn_valid), 32'd0);
      chk("rw_req4", 32'(imem_req), 32'd1);
      chk("rw_addr2", 32'(imem_addr), 32'h100);
      chk("rw_insn_kept", insn, 32'h01084020);
      chk("rw_pc_kept", 32'(insn_pc), 32'h003);
      fetch_one(32'h12345678, 12'h100, 5'd2, 5'd30);
      tick();

      // redirect together with imem_valid in WAIT
      chk("rv_addr0", 32'(imem_addr), 32'h101);
      tick();
      imem_valid  = 1'b1;
      imem_data   = 32'hAAAA5555;
      redirect    = 1'b1;
      redirect_pc = 12'h200;
      tick();
      imem_valid = 1'b0;
      redirect   = 1'b0;
      chk("rv_iv", 32'(insn_valid), 32'd0);
      chk("rv_req", 32'(imem_req), 32'd1);
      chk("rv_addr", 32'(imem_addr), 32'h200);
      chk("rv_insn_kept", insn, 32'h12345678);

      // redirect in FETCH to top of address space, then wrap
      redirect    = 1'b1;
      redirect_pc = 12'hFFF;
      tick();
      redirect = 1'b0;
      chk("rf_req", 32'(imem_req), 32'd0);
      chk("rf_addr", 32'(imem_addr), 32'hFFF);
      tick();
      chk("rf_req2", 32'(imem_req), 32'd0);
      imem_valid = 1'b1;
      imem_data  = 32'h0BADF00D;
      tick();
      imem_valid = 1'b0;
      chk("rf_iv", 32'(insn_valid), 32'd0);
      fetch_one(32'hF800007C, 12'hFFF, 5'd31, 5'd31);
      tick();
      chk("wrap_req", 32'(imem_req), 32'd1);
      chk("wrap_addr", 32'(imem_addr), 32'h000);

      // redirect beats stall in HOLD
      fetch_one(32'h08000008, 12'h000, 5'd1, 5'd2);
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 12'h055;
      tick();
      stall    = 1'b0;
      redirect = 1'b0;
      chk("rh_iv", 32'(insn_valid), 32'd0);
      chk("rh_req", 32'(imem_req), 32'd1);
      chk("rh_addr", 32'(imem_addr), 32'h055);
      chk_perf("rh", 32'd6, 32'd5);

      // reset mid-WAIT, late response after release
      tick();
      chk("mr_req_wait", 32'(imem_req), 32'd0);
      reset = 1'b0;
      #1;
      chk("mr_req", 32'(imem_req), 32'd0);
      chk("mr_addr", 32'(imem_addr), 32'd0);
      chk("mr_iv", 32'(insn_valid), 32'd0);
      chk("mr_insn", insn, 32'd0);
      chk("mr_plus1", 32'(insn_pc_plus1), 32'd1);
      chk_perf("mr", 32'd0, 32'd0);
      reset      = 1'b1;
      imem_valid = 1'b1;
      imem_data  = 32'h77777777;
      #1;
      chk("mr_start_req", 32'(imem_req), 32'd0);
      tick();
      imem_valid = 1'b0;
      chk("mr_fetch_iv", 32'(insn_valid), 32'd0);
      chk("mr_fetch_insn", insn, 32'd0);
      fetch_one(32'h28A00005, 12'h000, 5'd5, 5'd1);
      tick();
      chk("end_addr", 32'(imem_addr), 32'h001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
